// File: rtl/led_frame_sched.sv
// LED-domain frame scheduler: streams N_LED FIFO words per request to the serializer, pads black on underrun.
// Optional macro LED_FRAME_SCHED_FLUSH_EN: after a padded frame, late FIFO words are drained during GAP.
module led_frame_sched #(
   parameter int WORD_W    = 12,
   parameter int N_LED     = 35,
   parameter int GAP_CYC   = 1024,
   parameter int STALL_MAX = 64
) (
   input  logic              clk_slow,
   input  logic              rstn,
   input  logic              sched_en,
   input  logic              frame_req,
   input  logic              fifo_empty,
   input  logic [WORD_W-1:0] fifo_dout,
   output logic              fifo_rd,
   output logic              phy_valid,
   input  logic              phy_ready,
   output logic [WORD_W-1:0] phy_data,
   output logic              phy_sof,
   output logic              phy_eof,
   output logic              frame_done,
   output logic              req_drop,
   output logic              busy,
   output logic [7:0]        underrun_cnt
);
   localparam int CNT_W = (N_LED > 1) ? $clog2(N_LED) : 1;
   localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int STL_W = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N_LED - 1);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);
   localparam logic [STL_W-1:0] STALL_LIM = STL_W'(STALL_MAX - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_GAP = 2'd2} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] word_cnt_q;
   logic [GAP_W-1:0] gap_cnt_q;
   logic [STL_W-1:0] stall_q;
   logic             pad_q;
   logic             pend_q;
   logic             frame_done_q;
   logic             req_drop_q;
   logic [7:0]       underrun_q;

   logic             in_send_s;
   logic             xfer_s;
   logic             pad_start_s;
   logic [STL_W-1:0] stall_nx_s;

   // Serializer-facing handshake is combinational from state, counters and FIFO flags.
   always_comb begin
      in_send_s   = (state_q == S_SEND);
      phy_valid   = in_send_s && (!fifo_empty || pad_q);
      phy_data    = (in_send_s && !pad_q) ? fifo_dout : {WORD_W{1'b0}};
      xfer_s      = phy_valid && phy_ready;
      phy_sof     = phy_valid && (word_cnt_q == {CNT_W{1'b0}});
      phy_eof     = phy_valid && (word_cnt_q == LAST_WORD);
      stall_nx_s  = stall_q + STL_W'(1);
      pad_start_s = in_send_s && fifo_empty && !pad_q && (stall_nx_s == STALL_LIM);
`ifdef LED_FRAME_SCHED_FLUSH_EN
      fifo_rd     = (xfer_s && !pad_q) || ((state_q == S_GAP) && pad_q && !fifo_empty);
`else
      fifo_rd     = xfer_s && !pad_q;
`endif
   end

   assign frame_done   = frame_done_q;
   assign req_drop     = req_drop_q;
   assign busy         = (state_q != S_IDLE);
   assign underrun_cnt = underrun_q;

   // Frame FSM with word, gap and stall counters plus the one-deep request queue.
   always_ff @(posedge clk_slow) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         word_cnt_q   <= {CNT_W{1'b0}};
         gap_cnt_q    <= {GAP_W{1'b0}};
         stall_q      <= {STL_W{1'b0}};
         pad_q        <= 1'b0;
         pend_q       <= 1'b0;
         frame_done_q <= 1'b0;
         req_drop_q   <= 1'b0;
         underrun_q   <= 8'd0;
      end else begin
         frame_done_q <= 1'b0;
         req_drop_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (frame_req && sched_en) begin
                  state_q    <= S_SEND;
                  word_cnt_q <= {CNT_W{1'b0}};
                  stall_q    <= {STL_W{1'b0}};
                  pad_q      <= 1'b0;
               end else if (frame_req) begin
                  req_drop_q <= 1'b1;
               end
            end
            S_SEND: begin
               if (frame_req) begin
                  if (pend_q) req_drop_q <= 1'b1;
                  else        pend_q     <= 1'b1;
               end
               if (xfer_s) begin
                  stall_q <= {STL_W{1'b0}};
                  if (word_cnt_q == LAST_WORD) begin
                     state_q      <= S_GAP;
                     gap_cnt_q    <= {GAP_W{1'b0}};
                     frame_done_q <= 1'b1;
                  end else begin
                     word_cnt_q <= word_cnt_q + CNT_W'(1);
                  end
               end else if (pad_start_s) begin
                  // Padding is sticky for the rest of the frame, even if the FIFO refills.
                  stall_q <= stall_nx_s;
                  pad_q   <= 1'b1;
                  if (underrun_q != 8'hFF) underrun_q <= underrun_q + 8'd1;
               end else if (fifo_empty && !pad_q) begin
                  stall_q <= stall_nx_s;
               end
            end
            S_GAP: begin
               if (gap_cnt_q == GAP_LAST) begin
                  pend_q <= 1'b0;
                  if (frame_req && pend_q) req_drop_q <= 1'b1;
                  if ((pend_q || frame_req) && sched_en) begin
                     state_q    <= S_SEND;
                     word_cnt_q <= {CNT_W{1'b0}};
                     stall_q    <= {STL_W{1'b0}};
                     pad_q      <= 1'b0;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else begin
                  gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                  if (frame_req) begin
                     if (pend_q) req_drop_q <= 1'b1;
                     else        pend_q     <= 1'b1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_led_frame_sched.sv
// Bench for led_frame_sched: queue-based FIFO, per-cycle reference model, scenario table, corner sequences, random traffic.
module tb_led_frame_sched;
   localparam int WW = 12;
   localparam int N_LED = 35;
   localparam int GAP_CYC = 1024;
   localparam int STALL_MAX = 64;

   logic clk_slow, rstn, sched_en, frame_req, fifo_empty, fifo_rd;
   logic phy_valid, phy_ready, phy_sof, phy_eof, frame_done, req_drop, busy;
   logic [WW-1:0] fifo_dout, phy_data;
   logic [7:0] underrun_cnt;

   led_frame_sched #(.WORD_W(WW), .N_LED(N_LED), .GAP_CYC(GAP_CYC), .STALL_MAX(STALL_MAX)) dut (
      .clk_slow(clk_slow), .rstn(rstn), .sched_en(sched_en), .frame_req(frame_req),
      .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd(fifo_rd),
      .phy_valid(phy_valid), .phy_ready(phy_ready), .phy_data(phy_data),
      .phy_sof(phy_sof), .phy_eof(phy_eof), .frame_done(frame_done),
      .req_drop(req_drop), .busy(busy), .underrun_cnt(underrun_cnt));

   initial clk_slow = 1'b0;
   always #5 clk_slow = ~clk_slow;

   int n_checks = 0, n_fail = 0, cyc = 0;
   bit checking = 1'b0;
   logic [WW-1:0] fifo_q[$];

   // Reference model: frame progress in words, gap countdown, run of dry cycles.
   bit m_active, m_black, m_queued, m_done_p, m_drop_p;
   int m_gap_left, m_sent, m_dry, m_pads;

   // Observations of the last sampled cycle.
   logic obs_valid, obs_xfer, obs_sof, obs_eof, obs_rd, obs_done, obs_drop, obs_busy;
   logic [WW-1:0] obs_data;
   logic [7:0] obs_ucnt;
   logic [26:0] obs_vec;
   int exp_ucnt_total = 0;

   typedef struct {
      int preload; bit bp; int exp_data; int exp_pad; int exp_stall; int exp_inc;
   } scen_t;
   scen_t tbl[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic refresh();
      fifo_empty = (fifo_q.size() == 0);
      fifo_dout  = fifo_empty ? 12'hEEE : fifo_q[0];
   endtask

   task automatic push(input logic [WW-1:0] w);
      fifo_q.push_back(w);
      refresh();
   endtask

   task automatic start_frame();
      m_active = 1'b1; m_sent = 0; m_dry = 0; m_black = 1'b0;
   endtask

   task automatic note_req();
      if (frame_req) begin
         if (m_queued) m_drop_p = 1'b1;
         else          m_queued = 1'b1;
      end
   endtask

   task automatic model_step(input bit take);
      m_done_p = 1'b0; m_drop_p = 1'b0;
      if (!rstn) begin
         m_active = 1'b0; m_gap_left = 0; m_queued = 1'b0; m_black = 1'b0;
         m_pads = 0; m_sent = 0; m_dry = 0;
      end else if (m_active) begin
         note_req();
         if (take) begin
            m_dry = 0; m_sent++;
            if (m_sent == N_LED) begin m_active = 1'b0; m_gap_left = GAP_CYC; m_done_p = 1'b1; end
         end else if (fifo_empty && !m_black) begin
            m_dry++;
            if (m_dry == STALL_MAX - 1) begin m_black = 1'b1; m_pads++; end
         end
      end else if (m_gap_left == 1) begin
         m_gap_left = 0;
         if (frame_req && m_queued) m_drop_p = 1'b1;
         if ((m_queued || frame_req) && sched_en) start_frame();
         m_queued = 1'b0;
      end else if (m_gap_left > 1) begin
         m_gap_left--; note_req();
      end else if (frame_req) begin
         if (sched_en) start_frame();
         else          m_drop_p = 1'b1;
      end
   endtask

   task automatic cycle();
      bit offer, take, rd_e, rd_seen;
      logic [WW-1:0] e_data;
      logic [26:0] e_vec;
      @(negedge clk_slow);
      offer  = m_active && (!fifo_empty || m_black);
      take   = offer && phy_ready;
      e_data = (m_active && !m_black) ? fifo_dout : 12'h000;
      rd_e   = take && !m_black;
`ifdef LED_FRAME_SCHED_FLUSH_EN
      if (m_gap_left > 0 && m_black && !fifo_empty) rd_e = 1'b1;
`endif
      e_vec = {offer, e_data, offer && (m_sent == 0), offer && (m_sent == N_LED - 1), rd_e,
               m_done_p, m_drop_p, m_active || (m_gap_left > 0), 8'((m_pads > 255) ? 255 : m_pads)};
      obs_vec = {phy_valid, phy_data, phy_sof, phy_eof, fifo_rd, frame_done, req_drop, busy, underrun_cnt};
      obs_valid = phy_valid; obs_xfer = phy_valid && phy_ready; obs_data = phy_data;
      obs_sof = phy_sof; obs_eof = phy_eof; obs_rd = fifo_rd; obs_done = frame_done;
      obs_drop = req_drop; obs_busy = busy; obs_ucnt = underrun_cnt;
      if (checking) check("cycle_outputs", 32'(obs_vec), 32'(e_vec));
      model_step(take);
      rd_seen = fifo_rd;
      @(posedge clk_slow);
      #1;
      if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
      refresh();
      cyc++;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 3000; i++) begin
         cycle();
         if (obs_done) break;
      end
      check({tag, "_done_seen"}, 32'(obs_done), 32'd1);
   endtask

   // Returns the number of busy cycles observed after the call point.
   task automatic wait_idle(output int len);
      len = 0;
      for (int i = 0; i < 3000; i++) begin
         cycle();
         if (!obs_busy) break;
         len++;
      end
   endtask

   task automatic run_scen(input scen_t s, input int idx);
      int n_data, n_pad, n_stall, n_x, glen;
      bit order_ok, done;
      logic [WW-1:0] expw, sof_d, eof_d;
      string tag;
      tag = $sformatf("scen%0d", idx);
      n_data = 0; n_pad = 0; n_stall = 0; n_x = 0; order_ok = 1'b1; done = 1'b0;
      sof_d = 12'hFFF; eof_d = 12'hFFF;
      fifo_q.delete();
      for (int k = 0; k < s.preload; k++) fifo_q.push_back(WW'(k + 1));
      refresh();
      frame_req = 1'b1; cycle(); frame_req = 1'b0;
      for (int b = 0; b < 3000 && !done; b++) begin
         phy_ready = s.bp ? cyc[0] : 1'b1;
         cycle();
         if (obs_done) done = 1'b1;
         else begin
            if (!obs_valid) n_stall++;
            if (obs_xfer) begin
               expw = (n_x < s.preload) ? WW'(n_x + 1) : 12'h000;
               if (obs_data !== expw) order_ok = 1'b0;
               if (obs_sof) sof_d = obs_data;
               if (obs_eof) eof_d = obs_data;
               if (obs_rd) n_data++; else n_pad++;
               n_x++;
            end
         end
      end
      phy_ready = 1'b1;
      exp_ucnt_total += s.exp_inc;
      check({tag, "_done_seen"}, 32'(done), 32'd1);
      check({tag, "_data_words"}, n_data, s.exp_data);
      check({tag, "_pad_words"}, n_pad, s.exp_pad);
      check({tag, "_stall_cycles"}, n_stall, s.exp_stall);
      check({tag, "_word_order"}, 32'(order_ok), 32'd1);
      check({tag, "_sof_word"}, 32'(sof_d), (s.preload > 0) ? 32'd1 : 32'd0);
      check({tag, "_eof_word"}, 32'(eof_d), (s.preload >= N_LED) ? 32'(N_LED) : 32'd0);
      check({tag, "_underrun_cnt"}, 32'(obs_ucnt), exp_ucnt_total);
      wait_idle(glen);
      check({tag, "_gap_len"}, glen + 1, GAP_CYC);
   endtask

   initial begin
      int drops, n, glen, rds, sofs;
      tbl[0] = '{preload: 35, bp: 1'b0, exp_data: 35, exp_pad: 0,  exp_stall: 0,  exp_inc: 0};
      tbl[1] = '{preload: 35, bp: 1'b1, exp_data: 35, exp_pad: 0,  exp_stall: 0,  exp_inc: 0};
      tbl[2] = '{preload: 10, bp: 1'b0, exp_data: 10, exp_pad: 25, exp_stall: 63, exp_inc: 1};
      tbl[3] = '{preload: 0,  bp: 1'b0, exp_data: 0,  exp_pad: 35, exp_stall: 63, exp_inc: 1};
      tbl[4] = '{preload: 40, bp: 1'b1, exp_data: 35, exp_pad: 0,  exp_stall: 0,  exp_inc: 0};

      rstn = 1'b0; sched_en = 1'b1; frame_req = 1'b0; phy_ready = 1'b1; refresh();
      cycle();
      checking = 1'b1;
      cycle();
      check("reset_outputs", 32'(obs_vec), 32'd0);
      rstn = 1'b1;
      cycle();

      for (int i = 0; i < 5; i++) run_scen(tbl[i], i);

      // Three requests during frame 1: first queues, the other two drop.
      fifo_q.delete();
      for (int k = 0; k < 70; k++) fifo_q.push_back(WW'(k + 1));
      refresh();
      frame_req = 1'b1; cycle(); frame_req = 1'b0;
      drops = 0;
      for (int i = 0; i < 3000; i++) begin
         frame_req = (i == 5 || i == 10 || i == 15);
         cycle();
         frame_req = 1'b0;
         if (obs_drop) drops++;
         if (obs_done) break;
      end
      check("pend_done_seen", 32'(obs_done), 32'd1);
      check("pend_drop_count", drops, 2);
      n = 0;
      for (int i = 0; i < 2000; i++) begin
         cycle(); n++;
         if (obs_sof) break;
      end
      check("pend_frame2_start", n, GAP_CYC);
      check("pend_frame2_first_word", 32'(obs_data), 32'd36);
      wait_done("pend_f2");
      wait_idle(glen);

      // Reset asserted at word 17 of a frame.
      fifo_q.delete();
      for (int k = 0; k < 35; k++) fifo_q.push_back(WW'(k + 100));
      refresh();
      frame_req = 1'b1; cycle(); frame_req = 1'b0;
      n = 0;
      for (int i = 0; i < 200 && n < 17; i++) begin
         cycle();
         if (obs_xfer) n++;
      end
      rstn = 1'b0; cycle(); rstn = 1'b1;
      cycle();
      check("reset_mid_outputs", 32'(obs_vec), 32'd0);
      exp_ucnt_total = 0;

      // Disable mid-frame with a queued request: frame and gap finish, then idle.
      fifo_q.delete();
      for (int k = 0; k < 70; k++) fifo_q.push_back(WW'(k + 1));
      refresh();
      frame_req = 1'b1; cycle(); frame_req = 1'b0;
      cycle(); cycle();
      frame_req = 1'b1; cycle(); frame_req = 1'b0;
      sched_en = 1'b0;
      wait_done("dis");
      wait_idle(glen);
      check("dis_gap_len", glen + 1, GAP_CYC);
      sofs = 0;
      for (int i = 0; i < 50; i++) begin cycle(); if (obs_sof) sofs++; end
      check("dis_no_second_frame", sofs, 0);
      check("dis_fifo_left", fifo_q.size(), 35);
      frame_req = 1'b1; cycle(); frame_req = 1'b0;
      cycle();
      check("dis_idle_req_drop", 32'(obs_drop), 32'd1);
      sched_en = 1'b1;

      // Late words arriving in GAP after a padded frame.
      fifo_q.delete(); refresh();
      frame_req = 1'b1; cycle(); frame_req = 1'b0;
      wait_done("flush");
      for (int k = 0; k < 5; k++) push(WW'(k + 200));
      rds = 0;
      for (int i = 0; i < 3000; i++) begin
         cycle();
         if (obs_rd) rds++;
         if (!obs_busy) break;
      end
`ifdef LED_FRAME_SCHED_FLUSH_EN
      check("flush_gap_reads", rds, 5);
      check("flush_fifo_left", fifo_q.size(), 0);
`else
      check("flush_gap_reads", rds, 0);
      check("flush_fifo_left", fifo_q.size(), 5);
`endif

      // Random traffic against the model.
      fifo_q.delete(); refresh();
      for (int i = 0; i < 6000; i++) begin
         sched_en  = ($urandom_range(0, 99) < 97);
         frame_req = ($urandom_range(0, 149) == 0);
         phy_ready = ($urandom_range(0, 3) != 0);
         if (fifo_q.size() < 40 && $urandom_range(0, 2) == 0) push(WW'($urandom_range(0, 4095)));
         cycle();
      end
      frame_req = 1'b0; sched_en = 1'b1; phy_ready = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         if (fifo_q.size() < 40) push(WW'($urandom_range(0, 4095)));
         cycle();
         if (!obs_busy) break;
      end
      check("random_drain_idle", 32'(obs_busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/led_frame_sched.md
Name: led_frame_sched

Overview:
- Slow-clock-domain frame scheduler for the LED strip output path.
- On a frame request it drains exactly N_LED words from the first-word-fall-through async FIFO into the LED serializer through a valid/ready handshake, marking start and end of frame.
- After each frame it enforces an inter-frame latch gap. It queues one pending request and pads with black words if the FIFO underruns, so the strip never receives a short frame.

Parameters:
- WORD_W, 12, width of one RGB word (4 bits per colour).
- N_LED, 35, words per frame; equals the strip's zone-ordered LED count.
- GAP_CYC, 1024, minimum idle cycles between the last word of one frame and the first word of the next.
- STALL_MAX, 64, consecutive empty-FIFO cycles tolerated in SEND before padding starts.

Ports:
- clk_slow  in  1  LED-domain clock.
- rstn  in  1  synchronous active-low reset.
- sched_en  in  1  scheduler enable; when low, no new frames start.
- frame_req  in  1  single-cycle pulse: one frame is available (synchronised send_start).
- fifo_empty  in  1  FIFO empty flag (read side).
- fifo_dout  in  WORD_W  FIFO head word (FWFT, valid while !fifo_empty).
- fifo_rd  out  1  FIFO pop.
- phy_valid  out  1  word offered to serializer.
- phy_ready  in  1  serializer accepts word.
- phy_data  out  WORD_W  word to serializer.
- phy_sof  out  1  qualifies the first word of a frame.
- phy_eof  out  1  qualifies the last word of a frame.
- frame_done  out  1  pulse, one cycle after the last word transfers.
- req_drop  out  1  pulse, a frame_req was discarded.
- busy  out  1  state != IDLE.
- underrun_cnt  out  8  saturating count of frames that needed padding.

Behaviour:
- Clocking and reset: one clock, clk_slow; rstn is synchronous, active-low. On reset: state=IDLE, pend=0, pad=0, and all counters=0. All outputs are 0 on reset, including underrun_cnt.
- States: IDLE, SEND, GAP.
- IDLE: if frame_req&&sched_en, go to SEND next cycle, with word_cnt=0, pad=0 and stall=0.
- SEND:
  - phy_valid = !fifo_empty || pad. phy_data = pad ? 0 : fifo_dout.
  - A transfer occurs when phy_valid&&phy_ready. fifo_rd = transfer && !pad.
  - phy_sof = phy_valid && word_cnt==0. phy_eof = phy_valid && word_cnt==N_LED-1.
  - These outputs are combinational from state, counters and the FIFO flags.
  - Each transfer increments word_cnt. A transfer at word_cnt==N_LED-1 moves to GAP, and frame_done pulses in the first GAP cycle.
- Stall and padding:
  - stall increments each SEND cycle with fifo_empty && !pad, and clears on any transfer.
  - When stall reaches STALL_MAX-1 and FIFO is still empty: pad=1 for the rest of the frame, and underrun_cnt increments, saturating at 255.
  - Once pad=1 the FIFO is not read, even if it refills.
- GAP: counts GAP_CYC cycles with all phy outputs low. At expiry:
  - if pend && sched_en, go to SEND (pend cleared);
  - otherwise go to IDLE (pend cleared).
- Pending request:
  - frame_req in SEND or GAP with pend=0 sets pend.
  - With pend=1, frame_req pulses req_drop, and pend stays 1.
  - frame_req in IDLE with sched_en=0 pulses req_drop.
- Simultaneous events:
  - frame_req on the GAP expiry cycle counts as pend (enters SEND directly).
  - frame_req on the last transfer cycle sets pend.
- sched_en low mid-frame: the current frame and gap complete normally, then the block returns to IDLE and the pending request is discarded silently.
- Reset mid-frame: immediate return to IDLE next edge. The FIFO is not flushed by this block.
- Widths: word_cnt = clog2(N_LED), gap counter = clog2(GAP_CYC), stall counter = clog2(STALL_MAX).

Optional Feature:
- Macro: LED_FRAME_SCHED_FLUSH_EN.
- Defined: in GAP after a padded frame, fifo_rd = !fifo_empty, draining late words so the next frame stays aligned. Draining stops at GAP expiry.
- Not defined: no reads in GAP, and late words remain for the next frame.

Test Plan:
- Basic frame: preload 35 words 0x001..0x023, phy_ready=1, frame_req pulse → SEND next cycle; 35 transfers in order; sof on 0x001, eof on 0x023; frame_done 1 cycle after the last transfer; busy low GAP_CYC cycles later.
- Backpressure: toggle phy_ready every other cycle → data unchanged while not ready; fifo_rd only on ready cycles; 35 transfers total.
- Underrun: preload 10 words, then none → 10 data words, then 63 stall cycles, then 25 words of 0x000; eof on word 35; underrun_cnt=1.
- Pending and drop: three frame_req pulses during frame 1 → pend set by the first; req_drop pulses twice; frame 2 starts exactly GAP_CYC cycles after frame_done.
- Reset and disable: rstn low at word 17 → all outputs 0 next cycle and state IDLE. Separately, sched_en low mid-frame with pend=1 → frame finishes, then IDLE, and no second frame.
- Flush (macro on): underrun frame, then 5 late words written → 5 fifo_rd in GAP; FIFO empty at the next SEND.
